// File: rtl/alu_pkg.sv
// Shared constants for the registered datapath ALU: opcode encodings and widths.
package alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int SHAMT_W   = 6;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical barrel shifter, one log stage per shift-amount bit.
// Left shifts reuse the right-shift stages by bit-reversing input and output.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SH_W  = SHAMT_W
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SH_W-1:0]  shamt,
  input  logic             dir_left,
  output logic [WIDTH-1:0] data_out
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic [WIDTH-1:0] stage;

  always_comb begin
    stage = dir_left ? bit_rev(data_in) : data_in;
    for (int i = 0; i < SH_W; i++) begin
      if (shamt[i]) stage = stage >> (1 << i);
    end
    data_out = dir_left ? bit_rev(stage) : stage;
  end

endmodule

// File: rtl/alu_core.sv
// Registered 64-bit ALU: eight ops, one-cycle latency, registered zero flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       ALU_Op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid
);

  logic             do_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             slt_bit;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] op_res;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             out_valid_d, out_valid_q;

  // One adder serves ADD, SUB and SLT: subtract is A + ~B + 1.
  always_comb begin
    do_sub = (ALU_Op == ALU_SUB) || (ALU_Op == ALU_SLT);
    b_eff  = do_sub ? ~srcB : srcB;
    sum    = srcA + b_eff + {{(WIDTH-1){1'b0}}, do_sub};
    // Differing signs decide directly, so overflow of A-B cannot corrupt SLT.
    if (srcA[WIDTH-1] != srcB[WIDTH-1]) slt_bit = srcA[WIDTH-1];
    else                                slt_bit = sum[WIDTH-1];
  end

  alu_shifter #(
    .WIDTH (WIDTH),
    .SH_W  (SHAMT_W)
  ) u_shifter (
    .data_in  (srcA),
    .shamt    (srcB[SHAMT_W-1:0]),
    .dir_left (ALU_Op == ALU_SLL),
    .data_out (shift_out)
  );

  always_comb begin
    op_res = '0;
    case (ALU_Op)
      ALU_ADD, ALU_SUB: op_res = sum;
      ALU_AND:          op_res = srcA & srcB;
      ALU_OR:           op_res = srcA | srcB;
      ALU_XOR:          op_res = srcA ^ srcB;
      ALU_SLL, ALU_SRL: op_res = shift_out;
      ALU_SLT:          op_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default:          op_res = '0;
    endcase
  end

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = op_res;
      zero_d      = (op_res == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: issued ops push expected results tagged with
// the cycle they must appear in; a negedge monitor pops and compares.
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [63:0] srcA, srcB;
  logic [2:0]  ALU_Op;
  logic        in_valid;
  logic [63:0] result;
  logic        zero;
  logic        out_valid;

  alu_core #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .srcA      (srcA),
    .srcB      (srcB),
    .ALU_Op    (ALU_Op),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        z;
    int          due;
    int          op;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        rst_at_edge;
  logic [63:0] held_res = 64'd0;
  logic        held_z   = 1'b1;

  function automatic logic [63:0] ref_alu(int op, logic [63:0] a, logic [63:0] b);
    logic [5:0] sh;
    sh = b[5:0];
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst_n;
  end

  // Monitor: every negedge after the first edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_at_edge !== 1'b1) begin
        chk("reset_result", result, 64'd0);
        chk("reset_zero", {63'd0, zero}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        held_res = 64'd0;
        held_z   = 1'b1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) void'(sb_q.pop_front());
      end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("out_valid_op%0d", e.op), {63'd0, out_valid}, 64'd1);
        chk($sformatf("result_op%0d", e.op), result, e.res);
        chk($sformatf("zero_op%0d", e.op), {63'd0, zero}, {63'd0, e.z});
        held_res = e.res;
        held_z   = e.z;
      end else begin
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        chk("hold_result", result, held_res);
        chk("hold_zero", {63'd0, zero}, {63'd0, held_z});
      end
    end
  end

  task automatic issue(int op, logic [63:0] a, logic [63:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    ALU_Op   = 3'(op);
    srcA     = a;
    srcB     = b;
    e.res = ref_alu(op, a, b);
    e.z   = (e.res == 64'd0);
    e.due = cyc + 1;
    e.op  = op;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    ALU_Op   = 3'($urandom_range(0, 7));
    srcA     = {$urandom, $urandom};
    srcB     = {$urandom, $urandom};
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    ALU_Op   = 3'($urandom_range(0, 7));
    srcA     = {$urandom, $urandom};
    srcB     = {$urandom, $urandom};
  endtask

  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PF0  = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] PFF  = 64'hFF00_FF00_FF00_FF00;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; ALU_Op = 3'd0;
    srcA = {$urandom, $urandom}; srcB = {$urandom, $urandom};
    reset_cycle();
    reset_cycle();
    idle();
    idle();

    issue(0, 64'd512, 64'd4);
    issue(0, ONES, 64'd1);
    issue(1, 64'd5, 64'd5);
    issue(1, 64'd3, 64'd5);
    issue(7, ONES, 64'd1);
    issue(7, 64'd1, ONES);
    issue(7, MSB, 64'd1);
    issue(2, PF0, PFF);
    issue(3, PF0, PFF);
    issue(4, PF0, PFF);
    issue(5, 64'd1, 64'd63);
    issue(6, MSB, 64'd63);
    issue(5, 64'd1, 64'd64);
    issue(6, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFC0);
    for (int i = 0; i < 4; i++) idle();

    issue(0, 64'd10, 64'd20);
    reset_cycle();
    for (int i = 0; i < 3; i++) idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue($urandom_range(0, 7), {$urandom, $urandom}, {$urandom, $urandom});
    end
    for (int i = 0; i < 3; i++) idle();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results never presented, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_core.md
# alu_core

64-bit registered arithmetic/logic unit for the multicycle processor datapath. Computes one of eight operations on two 64-bit operands, selected by a 3-bit opcode from the control FSM. Registers the result and a zero flag one clock after the operands are presented. Feeds the ALUOut register path and branch-compare logic.

## Interface
- `WIDTH`, default 64: operand/result width. Only 64 is required to be verified.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `srcA`  in  WIDTH  operand A.
- `srcB`  in  WIDTH  operand B. For shifts, `srcB[5:0]` is the shift amount.
- `ALU_Op`  in  3  operation select.
- `in_valid`  in  1  capture enable. High means operands and opcode are sampled this edge.
- `result`  out  WIDTH  registered operation result.
- `zero`  out  1  registered flag: high iff `result == 0`.
- `out_valid`  out  1  high for exactly one cycle when `result` and `zero` were updated on the preceding edge.

## Operation
- Opcodes:
  - 000 ADD: A+B, modulo 2^64.
  - 001 SUB: A−B, modulo 2^64.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: A << B[5:0], zero fill.
  - 110 SRL: A >> B[5:0], logical, zero fill.
  - 111 SLT: 64'd1 if signed(A) < signed(B), else 64'd0.
- Arithmetic wraps and discards carry/overflow. No flag other than `zero` is produced.
- Shifts:
  - `B[63:6]` is ignored.
  - A shift of 0 passes A unchanged.
  - A shift of 63 leaves at most one significant bit.
- SLT uses a true two's-complement signed comparison, correct when the subtraction overflows. Example: A = 0x8000…0, B = 1 gives 1.
- `zero` is derived from the next-result value and registered in the same edge as `result`. It is never combinational on the outputs.
- When `in_valid` is low:
  - `result` and `zero` hold their previous values.
  - `out_valid` drops to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N with `in_valid`=1 appear on `result`/`zero`, with `out_valid`=1, after edge N.
- Throughput: one operation per cycle. Back-to-back `in_valid` produces back-to-back `out_valid`.
- No backpressure; the consumer must take the result in the `out_valid` cycle, or while it holds.
- Reset: on an edge with `rst_n`=0, `result`=0, `zero`=1, `out_valid`=0.
- Reset has priority over `in_valid` on the same edge; that operation is dropped.
- No asynchronous behaviour. Outputs change only on rising `clk`.
- Opcode changes while `in_valid`=0 have no effect.

## Structure
- Package `alu_pkg`:
  - localparam opcode constants `ALU_ADD`…`ALU_SLT` (3-bit).
  - Default `WIDTH`=64.
  - Shift-amount width `SHAMT_W`=6.
- Sub-module `alu_shifter`: combinational 64-bit logical left/right barrel shifter, six log stages, direction input.
- Top level holds:
  - the combinational op mux;
  - the adder/subtractor, shared, with B inverted plus carry-in for SUB/SLT;
  - the output registers.
- Default mux arm yields 0. Not reachable with 3-bit encoding, but required for lint-clean synthesis.

## Test plan
- Reset: hold `rst_n`=0 two cycles with random inputs and `in_valid`=1 → `result`=0, `zero`=1, `out_valid`=0.
- ADD: A=512, B=4, op 000, `in_valid`=1 → next cycle `result`=516, `zero`=0, `out_valid`=1. Also A=0xFFFF_FFFF_FFFF_FFFF, B=1 → `result`=0, `zero`=1 (wrap).
- SUB/SLT:
  - 5−5 → 0, `zero`=1.
  - 3−5 → 0xFFFF_FFFF_FFFF_FFFE.
  - SLT(−1, 1) → 1.
  - SLT(1, −1) → 0.
  - SLT(0x8000_0000_0000_0000, 1) → 1.
- Logic and shifts:
  - AND/OR/XOR of 0xF0F0…/0xFF00… against a reference model.
  - SLL(1, 63) → 0x8000_0000_0000_0000.
  - SRL(0x8000…0, 63) → 1.
  - SLL(1, B=64) → 1, since only `B[5:0]` is used.
- Hold and back-to-back:
  - Three consecutive `in_valid` ops → three consecutive `out_valid` with correct results.
  - Then `in_valid`=0 with changing inputs → `result` held, `out_valid`=0.
- Mid-stream reset: assert `rst_n`=0 on an edge where `in_valid`=1 → `result`=0, `zero`=1, `out_valid`=0; that operation never appears.
